// File: rtl/dsb_pkg.sv
// rtl/dsb_pkg.sv - port indices, flit header layout and XY route helper for the switch allocator
package dsb_pkg;

  localparam logic [2:0] P_IDX = 3'd0;
  localparam logic [2:0] S_IDX = 3'd1;
  localparam logic [2:0] W_IDX = 3'd2;
  localparam logic [2:0] N_IDX = 3'd3;
  localparam logic [2:0] E_IDX = 3'd4;

  // Header byte sits at flit bits [71:64]
  localparam int HDR_LSB = 64;

  typedef enum logic [1:0] {
    FT_SINGLE = 2'b00,
    FT_HEAD   = 2'b01,
    FT_BODY   = 2'b10,
    FT_TAIL   = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e ftype;
    logic [2:0] dst_x;
    logic [2:0] dst_y;
  } hdr_t;

  function automatic logic [2:0] route_xy(input logic [2:0] dst_x, input logic [2:0] dst_y,
                                          input logic [2:0] lx, input logic [2:0] ly);
    if (dst_x > lx)      return E_IDX;
    else if (dst_x < lx) return W_IDX;
    else if (dst_y > ly) return N_IDX;
    else if (dst_y < ly) return S_IDX;
    else                 return P_IDX;
  endfunction

endpackage

// File: rtl/dsb_switch_alloc_rr_arb5.sv
// rtl/dsb_switch_alloc_rr_arb5.sv - five-request round-robin arbiter searching from ptr+1
module rr_arb5 (
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] gnt_onehot,
  output logic [2:0] gnt_idx,
  output logic       gnt_any
);

  always_comb begin : p_search
    logic       found;
    logic [2:0] idx;
    int         j;
    found      = 1'b0;
    idx        = 3'd0;
    j          = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    for (int k = 1; k <= 5; k++) begin
      j   = (int'(ptr) + k) % 5;
      idx = j[2:0];
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = idx;
      end
    end
    gnt_any = |req;
  end

endmodule

// File: rtl/dsb_switch_alloc.sv
// rtl/dsb_switch_alloc.sv - XY route compute and wormhole switch allocator for the 5-port router
module dsb_switch_alloc
  import dsb_pkg::*;
#(
  parameter int NPORT       = 5,
  parameter int COORD_W     = 3,
  parameter int FLIT_LENGTH = 72
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COORD_W-1:0]   lx,
  input  logic [COORD_W-1:0]   ly,
  input  logic [NPORT-1:0]     in_valid,
  input  logic [NPORT*8-1:0]   in_hdr,
  input  logic [NPORT-1:0]     out_free,
  output logic [NPORT-1:0]     in_pop,
  output logic [NPORT-1:0]     xbar_vld,
  output logic [NPORT*3-1:0]   xbar_sel,
  output logic                 err_stray
);

  localparam int HDR_W = FLIT_LENGTH - HDR_LSB;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       st_q    [NPORT];
  logic [0:0]       st_d    [NPORT];
  logic [2:0]       owner_q [NPORT];
  logic [2:0]       owner_d [NPORT];
  logic [2:0]       ptr_q   [NPORT];
  logic [2:0]       ptr_d   [NPORT];

  hdr_t             hdr     [NPORT];
  logic [2:0]       route   [NPORT];
  logic [NPORT-1:0] locked;
  logic [4:0]       req     [NPORT];
  logic [4:0]       gnt_oh  [NPORT];
  logic [2:0]       gnt_idx [NPORT];
  logic [NPORT-1:0] gnt_any;

  logic [NPORT-1:0]   pop_c;
  logic [NPORT-1:0]   vld_c;
  logic [NPORT*3-1:0] sel_c;
  logic               stray_c;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      hdr[i]    = hdr_t'(in_hdr[HDR_W*i +: 8]);
      route[i]  = route_xy(hdr[i].dst_x, hdr[i].dst_y, lx, ly);
      locked[i] = 1'b0;
      for (int o = 0; o < NPORT; o++) begin
        if (st_q[o] == ST_LOCKED && owner_q[o] == 3'(i)) locked[i] = 1'b1;
      end
    end
    // Only unlocked packet starts compete; locked inputs follow their owner output
    for (int o = 0; o < NPORT; o++) begin
      req[o] = '0;
      for (int i = 0; i < NPORT; i++) begin
        req[o][i] = in_valid[i] && !locked[i] && route[i] == 3'(o) &&
                    (hdr[i].ftype == FT_SINGLE || hdr[i].ftype == FT_HEAD);
      end
    end
  end

  for (genvar g = 0; g < NPORT; g++) begin : g_arb
    rr_arb5 u_arb (
      .req        (req[g]),
      .ptr        (ptr_q[g]),
      .gnt_onehot (gnt_oh[g]),
      .gnt_idx    (gnt_idx[g]),
      .gnt_any    (gnt_any[g])
    );
  end

  always_comb begin
    pop_c   = '0;
    vld_c   = '0;
    sel_c   = '0;
    stray_c = 1'b0;
    st_d    = st_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    for (int o = 0; o < NPORT; o++) begin
      if (st_q[o] == ST_LOCKED) begin
        if (in_valid[owner_q[o]] && out_free[o]) begin
          vld_c[o]          = 1'b1;
          sel_c[3*o +: 3]   = owner_q[o];
          pop_c[owner_q[o]] = 1'b1;
          if (hdr[owner_q[o]].ftype == FT_TAIL) st_d[o] = ST_IDLE;
        end
      end else if (out_free[o] && gnt_any[o]) begin
        vld_c[o]        = 1'b1;
        sel_c[3*o +: 3] = gnt_idx[o];
        pop_c           = pop_c | gnt_oh[o];
        ptr_d[o]        = gnt_idx[o];
        if (hdr[gnt_idx[o]].ftype == FT_HEAD) begin
          st_d[o]    = ST_LOCKED;
          owner_d[o] = gnt_idx[o];
        end
      end
    end
    // Body/tail with no owning lock cannot be routed; drop it and flag
    for (int i = 0; i < NPORT; i++) begin
      if (in_valid[i] && !locked[i] &&
          (hdr[i].ftype == FT_BODY || hdr[i].ftype == FT_TAIL)) begin
        pop_c[i] = 1'b1;
        stray_c  = 1'b1;
      end
    end
  end

  assign in_pop    = rst ? pop_c : '0;
  assign xbar_vld  = rst ? vld_c : '0;
  assign xbar_sel  = rst ? sel_c : '0;
  assign err_stray = rst & stray_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NPORT; o++) begin
        st_q[o]    <= ST_IDLE;
        owner_q[o] <= 3'd0;
        ptr_q[o]   <= 3'd4;
      end
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
